// File: rtl/id_ex_stage_if.sv
// ID/EX bundle: decode-side inputs, MEM/WB forwarding sources and EX-side results.
interface id_ex_stage_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
);
    logic            StallE, FlushE, ValidD;
    logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD;
    logic [RA_W-1:0] Rs1D, Rs2D, RdD;
    logic [2:0]      ALUControlD;
    logic            ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD;
    logic [1:0]      ResultSrcD;

    logic [RA_W-1:0] RdM, RdW;
    logic            RegWriteM, RegWriteW;
    logic [XLEN-1:0] ALUResultM, ResultW;

    logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE, PCE, ImmExtE;
    logic [2:0]      ALUControlE;
    logic [RA_W-1:0] Rs1E, Rs2E, RdE;
    logic            RegWriteE, MemWriteE, BranchE, JumpE, ValidE;
    logic [1:0]      ResultSrcE;

    modport master (
        output StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD,
               ALUControlD, ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD,
               RdM, RdW, RegWriteM, RegWriteW, ALUResultM, ResultW,
        input  SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E, RdE,
               RegWriteE, MemWriteE, BranchE, JumpE, ValidE, ResultSrcE
    );

    modport slave (
        input  StallE, FlushE, ValidD, RD1D, RD2D, ImmExtD, PCD, Rs1D, Rs2D, RdD,
               ALUControlD, ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD,
               RdM, RdW, RegWriteM, RegWriteW, ALUResultM, ResultW,
        output SrcAE, SrcBE, WriteDataE, PCE, ImmExtE, ALUControlE, Rs1E, Rs2E, RdE,
               RegWriteE, MemWriteE, BranchE, JumpE, ValidE, ResultSrcE
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding feeding the ALU.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [2:0]      alu_ctrl;
        logic            alu_src;
        logic            reg_write;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic [1:0]      result_src;
    } ex_regs_t;

    ex_regs_t        d, q;
    logic [XLEN-1:0] fwd_a, fwd_b;

    always_comb begin
        d.valid      = bus.ValidD;
        d.rd1        = bus.RD1D;
        d.rd2        = bus.RD2D;
        d.imm        = bus.ImmExtD;
        d.pc         = bus.PCD;
        d.rs1        = bus.Rs1D;
        d.rs2        = bus.Rs2D;
        d.rd         = bus.RdD;
        d.alu_ctrl   = bus.ALUControlD;
        d.alu_src    = bus.ALUSrcD;
        d.reg_write  = bus.RegWriteD;
        d.mem_write  = bus.MemWriteD;
        d.branch     = bus.BranchD;
        d.jump       = bus.JumpD;
        d.result_src = bus.ResultSrcD;
    end

    // Flush beats stall: a bubble is all-zero, so it never writes or branches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           q <= '0;
        else if (bus.FlushE)  q <= '0;
        else if (!bus.StallE) q <= d;
    end

    // MEM is the younger producer, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_a = q.rd1;
        if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == q.rs1))
            fwd_a = bus.ALUResultM;
        else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == q.rs1))
            fwd_a = bus.ResultW;

        fwd_b = q.rd2;
        if (bus.RegWriteM && (bus.RdM != '0) && (bus.RdM == q.rs2))
            fwd_b = bus.ALUResultM;
        else if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == q.rs2))
            fwd_b = bus.ResultW;
    end

    assign bus.SrcAE       = fwd_a;
    assign bus.WriteDataE  = fwd_b;
    assign bus.SrcBE       = q.alu_src ? q.imm : fwd_b;
    assign bus.ALUControlE = q.alu_ctrl;
    assign bus.Rs1E        = q.rs1;
    assign bus.Rs2E        = q.rs2;
    assign bus.RdE         = q.rd;
    assign bus.PCE         = q.pc;
    assign bus.ImmExtE     = q.imm;
    assign bus.RegWriteE   = q.reg_write;
    assign bus.MemWriteE   = q.mem_write;
    assign bus.BranchE     = q.branch;
    assign bus.JumpE       = q.jump;
    assign bus.ValidE      = q.valid;
    assign bus.ResultSrcE  = q.result_src;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: pass-through, forwarding, stall/flush, reset.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage_if #(.XLEN(32), .RA_W(5)) bus ();
    id_ex_stage #(.XLEN(32), .RA_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  op;
        logic        alu_src;
        logic        regwm;
        logic [4:0]  rdm;
        logic [31:0] alum;
        logic        regww;
        logic [4:0]  rdw;
        logic [31:0] resw;
        logic [31:0] exp_a, exp_b, exp_wd;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_d(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                           input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [2:0] op, input logic alu_src,
                           input logic ctl);
        bus.ValidD = 1'b1;      bus.RD1D = rd1;      bus.RD2D = rd2;
        bus.ImmExtD = imm;      bus.PCD = pc;        bus.Rs1D = rs1;
        bus.Rs2D = rs2;         bus.RdD = rd;        bus.ALUControlD = op;
        bus.ALUSrcD = alu_src;  bus.RegWriteD = ctl; bus.MemWriteD = ctl;
        bus.BranchD = ctl;      bus.JumpD = ctl;     bus.ResultSrcD = {ctl, 1'b0};
    endtask

    task automatic drive_mw(input logic regwm, input logic [4:0] rdm, input logic [31:0] alum,
                            input logic regww, input logic [4:0] rdw, input logic [31:0] resw);
        bus.RegWriteM = regwm; bus.RdM = rdm; bus.ALUResultM = alum;
        bus.RegWriteW = regww; bus.RdW = rdw; bus.ResultW = resw;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".SrcAE"},       bus.SrcAE, 32'h0);
        check({tag, ".SrcBE"},       bus.SrcBE, 32'h0);
        check({tag, ".WriteDataE"},  bus.WriteDataE, 32'h0);
        check({tag, ".PCE"},         bus.PCE, 32'h0);
        check({tag, ".ImmExtE"},     bus.ImmExtE, 32'h0);
        check({tag, ".ALUControlE"}, 32'(bus.ALUControlE), 32'h0);
        check({tag, ".RdE"},         32'(bus.RdE), 32'h0);
        check({tag, ".Rs1E"},        32'(bus.Rs1E), 32'h0);
        check({tag, ".ValidE"},      32'(bus.ValidE), 32'h0);
        check({tag, ".RegWriteE"},   32'(bus.RegWriteE), 32'h0);
        check({tag, ".MemWriteE"},   32'(bus.MemWriteE), 32'h0);
        check({tag, ".BranchE"},     32'(bus.BranchE), 32'h0);
        check({tag, ".JumpE"},       32'(bus.JumpE), 32'h0);
        check({tag, ".ResultSrcE"},  32'(bus.ResultSrcE), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //        rd1          rd2          imm          rs1 rs2 rd  op    src  wm  rdm alum          ww  rdw resw          a            b            wd
        vecs[0] = '{32'h5,      32'h7,       32'h0,       1,  2,  3,  3'b000, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h5,       32'h7,       32'h7};
        vecs[1] = '{32'h1,      32'h2,       32'h0,       3,  4,  5,  3'b001, 0, 1, 3, 32'hAA,       1, 3, 32'hBB,       32'hAA,      32'h2,       32'h2};
        vecs[2] = '{32'h1,      32'h2,       32'h0,       3,  4,  5,  3'b001, 0, 0, 3, 32'hAA,       1, 3, 32'hBB,       32'hBB,      32'h2,       32'h2};
        vecs[3] = '{32'h9,      32'h0,       32'h0,       1,  0,  2,  3'b010, 0, 1, 0, 32'h55,       1, 0, 32'h66,       32'h9,       32'h0,       32'h0};
        vecs[4] = '{32'h11,     32'h1,       32'hFFFFFFFC,7,  6,  8,  3'b000, 1, 1, 6, 32'h1234,     0, 0, 32'h0,        32'h11,      32'hFFFFFFFC,32'h1234};
        vecs[5] = '{32'h3,      32'h4,       32'h0,       2,  8,  9,  3'b011, 0, 0, 8, 32'hDEAD,     1, 8, 32'hCAFE,     32'h3,       32'hCAFE,    32'hCAFE};
        vecs[6] = '{32'h3,      32'h4,       32'h10,      9,  9,  1,  3'b101, 0, 1, 9, 32'h600D,     1, 9, 32'hBAD,      32'h600D,    32'h600D,    32'h600D};
        vecs[7] = '{32'hA0,     32'hB0,      32'h0,       12, 13, 14, 3'b000, 0, 0, 12, 32'h1,       0, 13, 32'h2,       32'hA0,      32'hB0,      32'hB0};

        rst_n = 1'b0;
        bus.StallE = 1'b0; bus.FlushE = 1'b0;
        drive_d(32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 3'b000, 1'b0, 1'b0);
        bus.ValidD = 1'b0;
        drive_mw(0, 0, 32'h0, 0, 0, 32'h0);
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: capture on one edge, forwarding sources held live after it.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_d(vecs[i].rd1, vecs[i].rd2, vecs[i].imm, 32'h1000 + 32'(i * 4),
                    vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].op, vecs[i].alu_src, 1'b0);
            drive_mw(vecs[i].regwm, vecs[i].rdm, vecs[i].alum, vecs[i].regww, vecs[i].rdw, vecs[i].resw);
            @(posedge clk); #1;
            check($sformatf("v%0d.SrcAE", i), bus.SrcAE, vecs[i].exp_a);
            check($sformatf("v%0d.SrcBE", i), bus.SrcBE, vecs[i].exp_b);
            check($sformatf("v%0d.WriteDataE", i), bus.WriteDataE, vecs[i].exp_wd);
            check($sformatf("v%0d.ALUControlE", i), 32'(bus.ALUControlE), 32'(vecs[i].op));
            check($sformatf("v%0d.RdE", i), 32'(bus.RdE), 32'(vecs[i].rd));
            check($sformatf("v%0d.PCE", i), bus.PCE, 32'h1000 + 32'(i * 4));
            check($sformatf("v%0d.ValidE", i), 32'(bus.ValidE), 32'h1);
        end

        // Stall for three cycles while decode-side inputs keep changing.
        @(negedge clk);
        drive_d(32'h100, 32'h200, 32'h44, 32'h2000, 10, 11, 12, 3'b011, 1'b0, 1'b1);
        drive_mw(0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check("load.SrcAE", bus.SrcAE, 32'h100);
        check("load.RegWriteE", 32'(bus.RegWriteE), 32'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.StallE = 1'b1;
            drive_d(32'h900 + 32'(k), 32'h800, 32'h0, 32'h3000, 5'(20 + k), 21, 22, 3'b101, 1'b1, 1'b0);
            @(posedge clk); #1;
            check($sformatf("stall%0d.SrcAE", k), bus.SrcAE, 32'h100);
            check($sformatf("stall%0d.SrcBE", k), bus.SrcBE, 32'h200);
            check($sformatf("stall%0d.Rs1E", k), 32'(bus.Rs1E), 32'd10);
            check($sformatf("stall%0d.RdE", k), 32'(bus.RdE), 32'd12);
            check($sformatf("stall%0d.ALUControlE", k), 32'(bus.ALUControlE), 32'h3);
            check($sformatf("stall%0d.PCE", k), bus.PCE, 32'h2000);
            check($sformatf("stall%0d.ImmExtE", k), bus.ImmExtE, 32'h44);
            check($sformatf("stall%0d.RegWriteE", k), 32'(bus.RegWriteE), 32'h1);
            check($sformatf("stall%0d.JumpE", k), 32'(bus.JumpE), 32'h1);
            check($sformatf("stall%0d.ResultSrcE", k), 32'(bus.ResultSrcE), 32'h2);
        end

        // Forwarding still follows live M/W values during the stall.
        @(negedge clk);
        drive_mw(1, 10, 32'h77, 1, 11, 32'h88);
        #1;
        check("stallfwd.SrcAE", bus.SrcAE, 32'h77);
        check("stallfwd.WriteDataE", bus.WriteDataE, 32'h88);
        check("stallfwd.SrcBE", bus.SrcBE, 32'h88);

        // Flush and stall together: flush wins.
        @(negedge clk);
        bus.FlushE = 1'b1;
        @(posedge clk); #1;
        check("flush.ValidE", 32'(bus.ValidE), 32'h0);
        check("flush.RegWriteE", 32'(bus.RegWriteE), 32'h0);
        check("flush.MemWriteE", 32'(bus.MemWriteE), 32'h0);
        check("flush.BranchE", 32'(bus.BranchE), 32'h0);
        check("flush.JumpE", 32'(bus.JumpE), 32'h0);
        check("flush.RdE", 32'(bus.RdE), 32'h0);
        check("flush.PCE", bus.PCE, 32'h0);
        check("flush.SrcAE", bus.SrcAE, 32'h0);

        // Reload, then assert reset between edges.
        @(negedge clk);
        bus.FlushE = 1'b0; bus.StallE = 1'b0;
        drive_d(32'h123, 32'h456, 32'h789, 32'h4000, 1, 2, 3, 3'b010, 1'b1, 1'b1);
        drive_mw(0, 0, 32'h0, 0, 0, 32'h0);
        @(posedge clk); #1;
        check("reload.SrcAE", bus.SrcAE, 32'h123);
        check("reload.SrcBE", bus.SrcBE, 32'h789);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        check_all_zero("midreset_edge");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("after_reset.SrcAE", bus.SrcAE, 32'h123);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
